// File: rtl/board_wb_pkg.sv
// rtl/board_wb_pkg.sv - shared widths, FSM state type and cell field layout for the board store
package board_wb_pkg;

  localparam int BOARD_ADDR_W = 8;
  localparam int BOARD_DATA_W = 16;
  localparam int BOARD_DEPTH  = 256;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } board_mem_state_t;

  // Cell word layout used by the game logic
  localparam int CELL_NBR_LSB      = 0;
  localparam int CELL_NBR_MSB      = 3;
  localparam int CELL_MINE_BIT     = 4;
  localparam int CELL_REVEALED_BIT = 5;
  localparam int CELL_FLAG_BIT     = 6;

endpackage

// File: rtl/board_ram_sp.sv
// rtl/board_ram_sp.sv - single-port synchronous RAM, one write port and a registered read
module board_ram_sp
  import board_wb_pkg::*;
#(
  parameter int ADDR_W = BOARD_ADDR_W,
  parameter int DATA_W = BOARD_DATA_W,
  parameter int DEPTH  = BOARD_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write when enabled; read is registered every cycle (old data on a same-edge write)
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/board_mem_wb_slave.sv
// rtl/board_mem_wb_slave.sv - pipelined wishbone slave owning the 16x16 board store, self-clearing
module board_mem_wb_slave
  import board_wb_pkg::*;
#(
  parameter int                ADDR_W    = BOARD_ADDR_W,
  parameter int                DATA_W    = BOARD_DATA_W,
  parameter int                DEPTH     = BOARD_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [ADDR_W-1:0] adr_o,
  input  logic [DATA_W-1:0] dat_o,
  input  logic              we_o,
  input  logic              stb_o,
  input  logic              cyc_o,
  output logic [DATA_W-1:0] dat_i,
  output logic              ack_i,
  output logic              stall_i,
  input  logic              clear_req,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  board_mem_state_t  state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              in_range;
  logic              ack_q;
  logic              rd_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range = ({1'b0, adr_o} < DEPTH_L);

  // State register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= CLEAR;
    end else begin
      state <= state_n;
    end
  end

  // Leave CLEAR after the last cell is written; a new-game request always re-enters it
  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   if (!clear_req && cnt == LAST_IDX) state_n = SERVE;
      SERVE:   if (clear_req) state_n = CLEAR;
      default: state_n = CLEAR;
    endcase
  end

  // RAM port steering: clear counter owns the RAM in CLEAR, the bus owns it in SERVE
  always_comb begin
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = adr_o;
    ram_wdata = dat_o;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = CLEAR_VAL;
      end
      SERVE: begin
        accept = cyc_o & stb_o & ~stall_i;
        ram_we = accept & we_o & in_range;
      end
      default: ;
    endcase
  end

  // Clear counter advances through the array; a clear request restarts it from cell 0
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cnt <= '0;
    end else if (state == CLEAR && !clear_req) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Registered stall/busy track the upcoming state; ack and read-valid follow accept by one cycle
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stall_i <= 1'b1;
      busy    <= 1'b1;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      stall_i <= (state_n == CLEAR);
      busy    <= (state_n == CLEAR);
      ack_q   <= accept;
      rd_q    <= accept & ~we_o & in_range;
    end
  end

  // An ack is withdrawn if the master drops cyc_o; data is driven only with a read ack
  assign ack_i = ack_q & cyc_o;
  assign dat_i = (ack_i && rd_q) ? ram_rdata : '0;

  board_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (CLK_I),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_board_mem_wb_slave.sv
// tb/tb_board_mem_wb_slave.sv - scoreboard bench for the board store wishbone slave
module tb_board_mem_wb_slave;

  logic        clk = 1'b0;
  logic        RST_I;
  logic [7:0]  adr_o;
  logic [15:0] dat_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [15:0] dat_i;
  logic        ack_i;
  logic        stall_i;
  logic        clear_req;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_model [256];
  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;

  board_mem_wb_slave dut (
    .CLK_I     (clk),
    .RST_I     (RST_I),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .we_o      (we_o),
    .stb_o     (stb_o),
    .cyc_o     (cyc_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i),
    .stall_i   (stall_i),
    .clear_req (clear_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cycle);
    end
  endtask

  // Every cycle: ack must appear exactly when the scoreboard head is due, data must match
  always @(negedge clk) begin
    logic exp_ack;
    exp_t e;
    exp_ack = (sb.size() > 0) && (sb[0].due == cycle);
    check("ack", {31'b0, ack_i}, {31'b0, exp_ack});
    if (exp_ack) begin
      e = sb.pop_front();
      if (ack_i) check("rdata", {16'b0, dat_i}, {16'b0, e.data});
    end else if (!ack_i) begin
      check("dat_idle", {16'b0, dat_i}, 32'h0);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
  endtask

  task automatic bus(input logic w, input logic [7:0] a, input logic [15:0] d,
                     input logic clr, input logic expect_ack);
    @(posedge clk); #1;
    cyc_o = 1'b1; stb_o = 1'b1; we_o = w; adr_o = a; dat_o = d; clear_req = clr;
    if (expect_ack) sb.push_back('{(w ? 16'h0000 : mem_model[a]), cycle + 1});
    if (w) mem_model[a] = d;
    if (clr) model_clear();
  endtask

  task automatic idle();
    @(posedge clk); #1;
    stb_o = 1'b0; we_o = 1'b0; clear_req = 1'b0;
  endtask

  // Counts consecutive sampled cycles with stall high, bounded
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (stall_i) n++;
      else break;
    end
    check(tag, n, 256);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cycle=%0d", cycle);
    $fatal(1);
  end

  initial begin
    RST_I = 1'b0; cyc_o = 1'b0; stb_o = 1'b0; we_o = 1'b0;
    adr_o = '0; dat_o = '0; clear_req = 1'b0;
    model_clear();
    #1 RST_I = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, stall_i}, 32'h1);
    check("rst_busy",  {31'b0, busy},    32'h1);
    check("rst_ack",   {31'b0, ack_i},   32'h0);
    check("rst_dat",   {16'b0, dat_i},   32'h0);

    // Release reset with a read strobe held; it is accepted as soon as stall drops
    @(posedge clk); #1;
    RST_I = 1'b0; cyc_o = 1'b1; stb_o = 1'b1; we_o = 1'b0; adr_o = 8'h00;
    wait_clear("reset_clear_len");
    sb.push_back('{mem_model[8'h00], cycle + 1});
    idle();

    // Write then read same cell on consecutive cycles
    bus(1'b1, 8'h3C, 16'hA5A5, 1'b0, 1'b1);
    bus(1'b0, 8'h3C, 16'h0000, 1'b0, 1'b1);
    idle();
    idle();

    // Pipelined burst: write value=address, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) bus(1'b1, 8'(i), 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) bus(1'b0, 8'(i), 16'h0000, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("stall_serve", {31'b0, stall_i}, 32'h0);

    // Mixed random traffic including the extreme cells
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = (i % 10 == 0) ? 8'hFF : ((i % 10 == 1) ? 8'h00 : 8'($urandom_range(0, 255)));
      bus(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0, 1'b1);
      if (i % 7 == 3) idle();
    end
    idle();

    // Abort: read accepted, master drops cyc during ack cycle
    bus(1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b1);
    bus(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    cyc_o = 1'b0; stb_o = 1'b0;
    bus(1'b0, 8'h10, 16'h0000, 1'b0, 1'b1);
    idle();
    idle();

    // New game: clear requested together with a read of the last cell
    bus(1'b1, 8'hFF, 16'h00FF, 1'b0, 1'b1);
    bus(1'b0, 8'hFF, 16'h0000, 1'b1, 1'b1);
    idle();
    wait_clear("newgame_clear_len");
    bus(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b1);
    bus(1'b0, 8'h3C, 16'h0000, 1'b0, 1'b1);
    idle();
    idle();

    // Reset in the middle of a clear restarts the full clear
    @(posedge clk); #1;
    RST_I = 1'b1; cyc_o = 1'b0; stb_o = 1'b0;
    repeat (2) @(posedge clk);
    #1 RST_I = 1'b0;
    repeat (100) @(posedge clk);
    #1 RST_I = 1'b1;
    model_clear();
    @(negedge clk);
    check("midrst_stall", {31'b0, stall_i}, 32'h1);
    check("midrst_busy",  {31'b0, busy},    32'h1);
    @(posedge clk); #1;
    RST_I = 1'b0; cyc_o = 1'b1;
    wait_clear("midrst_clear_len");
    bus(1'b0, 8'h05, 16'h0000, 1'b0, 1'b1);
    idle();
    idle();

    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_mem_wb_slave.md
Name: board_mem_wb_slave

Overview:
Wishbone pipelined slave that owns the 16x16 Minesweeper board store: 256 cells of 16 bits, addressed {row[3:0], col[3:0]}. It sits directly downstream of the game-logic master on the wishbone bus and answers its reads and writes. It self-clears the board after reset and on a new-game request, and stalls the bus while clearing.

Parameters:
ADDR_W, 8, address width (cell index)
DATA_W, 16, cell word width
DEPTH, 256, number of implemented cells (must be <= 2**ADDR_W)
CLEAR_VAL, 16'h0000, value written to every cell during clear

Ports:
CLK_I  input  1  system clock
RST_I  input  1  asynchronous active-high reset
adr_o  input  ADDR_W  address from master (bus naming kept master-side, as in the interface)
dat_o  input  DATA_W  write data from master
we_o  input  1  1 = write, 0 = read
stb_o  input  1  strobe, request valid
cyc_o  input  1  bus cycle active
dat_i  output  DATA_W  read data to master
ack_i  output  1  transaction acknowledge
stall_i  output  1  slave cannot accept a request this cycle
clear_req  input  1  single-cycle pulse: re-initialise the board (new game)
busy  output  1  high while a clear is in progress

Behaviour:
- One clock (CLK_I). RST_I is asynchronous and active-high.
- Reset values: state=CLEAR, clear counter=0, ack_i=0, dat_i=0, stall_i=1, busy=1.
- stall_i and busy are registered. Both equal (state==CLEAR).
- FSM states: CLEAR and SERVE.
- CLEAR:
  - Each cycle writes CLEAR_VAL to mem[cnt], then cnt++.
  - On the edge that writes cnt==DEPTH-1, go to SERVE. stall_i falls on that edge.
  - First request can be accepted DEPTH cycles after reset release.
  - No acks are generated in CLEAR. stb_o is ignored because stall_i=1.
- SERVE:
  - A request is accepted on an edge where cyc_o & stb_o & !stall_i.
  - Write: mem[adr_o] <= dat_o on the accept edge. ack_i=1 in the next cycle. dat_i=0.
  - Read: mem[adr_o] is sampled on the accept edge. dat_i=value and ack_i=1 in the next cycle.
  - Latency is exactly 1 cycle from accept to ack.
  - Back-to-back accepts produce back-to-back acks, giving 1 transaction per cycle.
  - Read-after-write, same address, consecutive cycles: the read returns the newly written data.
  - dat_i=0 whenever ack_i=0.
- Abort: if cyc_o is low during the ack cycle, ack_i is forced to 0. A write already performed is not undone.
- Out-of-range address (adr_o >= DEPTH): write is ignored, read returns 0, ack is still generated.
- clear_req sampled in SERVE:
  - State is CLEAR on the next edge, cnt=0.
  - A request accepted on the same edge still completes: its ack follows next cycle, and read data is the pre-clear value.
- clear_req sampled in CLEAR: cnt restarts at 0, so the clear is extended.
- RST_I asserted mid-clear or mid-transaction:
  - Immediate return to reset values.
  - A pending ack is dropped.
  - Memory contents are undefined until the clear completes.
- No wait states other than the clear window. stall_i is never asserted in SERVE.

Decomposition:
- Package board_wb_pkg:
  - BOARD_ADDR_W=8, BOARD_DATA_W=16, BOARD_DEPTH=256.
  - typedef enum logic {CLEAR, SERVE} board_mem_state_t.
  - Cell field constants: mine bit, revealed bit, flag bit, neighbour count [3:0].
- One sub-module, board_ram_sp:
  - Single-port synchronous RAM with one write port and one registered read.
  - No reset on the array.
  - The top muxes the clear counter vs. bus address and data into it.

Test Plan:
- Reset, then stall release: release RST_I, hold stb_o=1 -> stall_i=1 for exactly 256 cycles, ack_i never high, then stall_i=0 and busy=0.
- Write then read: write adr 8'h3C data 16'hA5A5, then read 8'h3C next cycle -> ack on each following cycle, read dat_i=16'hA5A5, write-ack dat_i=0.
- Pipelined burst: reads of 8'h00..8'h0F on 16 consecutive cycles after writing cell value=address -> 16 consecutive acks, dat_i=0x0000..0x000F in order.
- New game clear: write 16'h00FF to 8'hFF, pulse clear_req together with a read of 8'hFF -> that read acks with 16'h00FF, stall_i high for 256 cycles, later read of 8'hFF returns 16'h0000.
- Abort: accept a read of 8'h10, drop cyc_o in the next cycle -> ack_i stays 0; a following read of 8'h10 acks normally.
- Reset mid-clear: assert RST_I at clear count 100 -> stall_i stays 1, and the clear restarts and lasts a full 256 cycles after release.
